crc8_pkt_ctrl: RTL and testbench

//  Per-packet sequencer for the router's CRC-8 datapath (poly x^8+x^7+x^6+x^3+x^2+x+1, init 0xFF, no final xor).

---
 rtl/crc8_pkg.sv | 20 ++
 rtl/crc8_acc.sv | 24 ++
 rtl/crc8_pkt_ctrl.sv | 131 +++++++++++++
 tb/tb_crc8_pkt_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions (poly 0xCF, init 0xFF, MSB-first, no final xor) and FSM encoding.
package crc8_pkg;

  localparam logic [7:0] CRC8_INIT  = 8'hFF;
  localparam logic [7:0] CRC8_POLY  = 8'hCF;
  localparam logic       MODE_GEN   = 1'b1;
  localparam logic       MODE_CHECK = 1'b0;

  typedef enum logic [1:0] {IDLE, DATA, APPEND} state_e;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_acc.sv
// CRC-8 accumulator register: synchronous clear to CRC8_INIT (priority) and byte-update enable.
module crc8_acc
  import crc8_pkg::*;
(
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      crc_q <= CRC8_INIT;
    end else if (en_i) begin
      crc_q <= crc8_next(crc_q, data_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/crc8_pkt_ctrl.sv
// Per-packet CRC-8 sequencer: GEN appends the CRC byte, CHECK verifies the trailing CRC byte.
// Optional CRC_PKT_STATS_EN adds saturating good/bad packet counters.
module crc8_pkt_ctrl
  import crc8_pkg::*;
#(
  parameter  int MAX_LEN = 32,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_gen,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_last,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       pkt_done,
  output logic       pkt_crc_ok,
  output logic       pkt_len_err
`ifdef CRC_PKT_STATS_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
`endif
);

  state_e           state_q, state_d;
  logic             mode_q;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_acc_q;
  logic             done_q, ok_q, lerr_q;
  logic [7:0]       crc;

  logic gen_mode, s_hs, chk_end, gen_end, pkt_end;

  // The mode is live on the first byte and latched for the rest of the packet.
  assign gen_mode = (state_q == IDLE) ? mode_gen : mode_q;
  assign s_hs     = s_valid & m_ready & ~rst & (state_q != APPEND);
  assign chk_end  = s_hs & s_last & (gen_mode == MODE_CHECK);
  assign gen_end  = (state_q == APPEND) & m_ready & ~rst;
  assign pkt_end  = chk_end | gen_end;
  assign cnt_d    = (cnt_q == LEN_W'(MAX_LEN)) ? cnt_q : cnt_q + LEN_W'(1);

  crc8_acc u_acc (
    .clk_i  (clk),
    .clr_i  (rst | pkt_end),
    .en_i   (s_hs & ~chk_end),
    .data_i (s_data),
    .crc_o  (crc)
  );

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_last  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE, DATA: begin
          s_ready = m_ready;
          m_valid = s_valid;
          m_data  = s_data;
          m_last  = s_last & (gen_mode == MODE_CHECK);
          if (s_hs) begin
            if (s_last) state_d = (gen_mode == MODE_GEN) ? APPEND : IDLE;
            else        state_d = DATA;
          end
        end
        APPEND: begin
          m_valid = 1'b1;
          m_data  = crc;
          m_last  = 1'b1;
          if (gen_end) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_CHECK;
      cnt_q     <= '0;
      err_acc_q <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      lerr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= pkt_end;
      if (state_q == IDLE && s_hs) mode_q <= mode_gen;
      if (pkt_end) begin
        cnt_q     <= '0;
        err_acc_q <= 1'b0;
        ok_q      <= ~err_acc_q & (gen_end | (crc == s_data));
        lerr_q    <= err_acc_q;
      end else if (s_hs) begin
        cnt_q <= cnt_d;
        // Reaching MAX_LEN on a non-final byte means the packet will overrun.
        if (!s_last && cnt_d == LEN_W'(MAX_LEN)) err_acc_q <= 1'b1;
      end
    end
  end

  assign pkt_done    = done_q;
  assign pkt_crc_ok  = ok_q;
  assign pkt_len_err = lerr_q;

`ifdef CRC_PKT_STATS_EN
  logic [15:0] good_q, bad_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      good_q <= '0;
      bad_q  <= '0;
    end else if (done_q) begin
      if (ok_q) good_q <= (good_q == 16'hFFFF) ? good_q : good_q + 16'd1;
      else      bad_q  <= (bad_q  == 16'hFFFF) ? bad_q  : bad_q  + 16'd1;
    end
  end

  assign good_cnt = good_q;
  assign bad_cnt  = bad_q;
`endif

endmodule

// File: tb/tb_crc8_pkt_ctrl.sv
// Scoreboard bench for crc8_pkt_ctrl: driver pushes expected bytes/status, monitor pops and compares.
module tb_crc8_pkt_ctrl;

  localparam int MAX_LEN = 32;

  logic       clk = 1'b0;
  logic       rst, mode_gen, s_valid, s_last, m_ready;
  logic [7:0] s_data;
  logic       s_ready, m_valid, m_last, pkt_done, pkt_crc_ok, pkt_len_err;
  logic [7:0] m_data;
`ifdef CRC_PKT_STATS_EN
  logic [15:0] good_cnt, bad_cnt;
`endif

  crc8_pkt_ctrl #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .mode_gen(mode_gen),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .pkt_done(pkt_done), .pkt_crc_ok(pkt_crc_ok), .pkt_len_err(pkt_len_err)
`ifdef CRC_PKT_STATS_EN
    , .good_cnt(good_cnt), .bad_cnt(bad_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int mr_mode = 2;
  int exp_good = 0, exp_bad = 0;

  logic [9:0] exp_bytes[$];   // {is_crc_append, last, data}
  logic [1:0] exp_stat[$];    // {ok, len_err}
  logic [7:0] crc_tbl[256];
  logic [9:0] eb;
  logic [1:0] es;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Table built from polynomial long division of v*x^8 by x^8+x^7+x^6+x^3+x^2+x+1.
  task automatic build_table();
    logic [15:0] rem;
    for (int v = 0; v < 256; v++) begin
      rem = 16'(v) << 8;
      for (int b = 15; b >= 8; b--) begin
        if (rem[b]) rem = rem ^ (16'h01CF << (b - 8));
      end
      crc_tbl[v] = rem[7:0];
    end
  endtask

  function automatic logic [7:0] ref_crc(input logic [7:0] q[$], input int n);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 0; i < n; i++) c = crc_tbl[c ^ q[i]];
    return c;
  endfunction

  // Downstream ready pattern: 0 random, 1 toggling, 2 always ready.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        0:       m_ready = ($urandom_range(0, 3) != 0);
        1:       m_ready = ~m_ready;
        default: m_ready = 1'b1;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_valid && m_ready) begin
          if (exp_bytes.size() == 0) begin
            vectors++; fails++;
            $display("FAIL unexpected_byte: got %0h expected none", m_data);
          end else begin
            eb = exp_bytes.pop_front();
            check("m_byte", {23'd0, m_last, m_data}, {23'd0, eb[8:0]});
            if (eb[9]) check("s_ready_in_append", {31'd0, s_ready}, 32'd0);
          end
        end
        if (pkt_done) begin
          if (exp_stat.size() == 0) begin
            vectors++; fails++;
            $display("FAIL unexpected_pkt_done: got ok=%0b err=%0b expected none", pkt_crc_ok, pkt_len_err);
          end else begin
            es = exp_stat.pop_front();
            check("pkt_status", {30'd0, pkt_crc_ok, pkt_len_err}, {30'd0, es});
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit done;
    done = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) begin
      vectors++; fails++;
      $display("FAIL handshake_timeout: got no s_ready expected accept of %0h", d);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_pkt(input logic gen, input logic [7:0] q[$], input bit gaps);
    int n;
    logic ok, err;
    n   = q.size();
    err = (n > MAX_LEN);
    for (int i = 0; i < n; i++)
      exp_bytes.push_back({1'b0, (!gen && i == n - 1), q[i]});
    if (gen) begin
      exp_bytes.push_back({1'b1, 1'b1, ref_crc(q, n)});
      ok = !err;
    end else begin
      ok = !err && (ref_crc(q, n - 1) == q[n - 1]);
    end
    exp_stat.push_back({ok, err});
    if (ok) exp_good++; else exp_bad++;
    mode_gen = gen;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_byte(q[i], i == n - 1);
      mode_gen = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_bytes.size() != 0 || exp_stat.size() != 0) && t < 500) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 500) begin
      vectors++; fails++;
      $display("FAIL drain_timeout: got %0d bytes %0d status pending expected 0", exp_bytes.size(), exp_stat.size());
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int n;
    build_table();
    rst = 1'b1; mode_gen = 1'b1; s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data",  {24'd0, m_data},  32'd0);
    check("rst_m_last",  {31'd0, m_last},  32'd0);
    check("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
    check("rst_ok",      {31'd0, pkt_crc_ok}, 32'd0);
    check("rst_len_err", {31'd0, pkt_len_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Directed spec vectors
    q = {8'h00};               send_pkt(1'b1, q, 0);
    q = {8'h00, 8'hD2};        send_pkt(1'b0, q, 0);
    q = {8'h00, 8'hD3};        send_pkt(1'b0, q, 0);
    q = {8'hFF};               send_pkt(1'b0, q, 0);
    q = {8'hFE};               send_pkt(1'b0, q, 0);
    drain();
    mr_mode = 1;
    q = {8'h00};               send_pkt(1'b1, q, 0);
    q = {8'h00};               send_pkt(1'b1, q, 0);
    drain();
    mr_mode = 2;
    q = {};
    for (int i = 0; i < MAX_LEN; i++) q.push_back(8'($urandom));
    q.push_back(ref_crc(q, MAX_LEN));
    send_pkt(1'b0, q, 0);
    q = {};
    for (int i = 0; i < MAX_LEN - 1; i++) q.push_back(8'($urandom));
    q.push_back(ref_crc(q, MAX_LEN - 1));
    send_pkt(1'b0, q, 0);
    drain();

    // Reset in the middle of a packet, then a fresh GEN packet
    mode_gen = 1'b1;
    exp_bytes.push_back({1'b0, 1'b0, 8'h11});
    exp_bytes.push_back({1'b0, 1'b0, 8'h22});
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef CRC_PKT_STATS_EN
    exp_good = 0; exp_bad = 0;
`endif
    q = {8'h00};               send_pkt(1'b1, q, 0);
    drain();

    // Randomized packets, random modes, lengths and backpressure
    mr_mode = 0;
    for (int p = 0; p < 60; p++) begin
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_LEN - 1, MAX_LEN + 4) : $urandom_range(1, 8);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) q[n - 1] = ref_crc(q, n - 1);
      send_pkt(1'($urandom_range(0, 1)), q, 1);
    end
    drain();

`ifdef CRC_PKT_STATS_EN
    check("good_cnt", {16'd0, good_cnt}, 32'(exp_good));
    check("bad_cnt",  {16'd0, bad_cnt},  32'(exp_bad));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
